hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Parametrised successor to the ID-stage hazard detector for the ARM 5-stage pipeline (IF/ID/EXE/MEM/WB).
- Supports N source operands with per-source valid bits, load-use detection, and memory-wait freeze.
- Produces registered per-source forwarding selects that travel with the instruction into EXE.
- Keeps saturating performance counters for stall cycles and load-use events.

Parameters:
- REG_AW, 4, register address width.
- NUM_SRC, 3, number of source operands checked per instruction (1..4).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- forward_en  in  1  1 = forwarding mode, 0 = stall-only mode.
- src_addr  in  NUM_SRC*REG_AW  ID-stage source registers; source i occupies bits [i*REG_AW +: REG_AW].
- src_valid  in  NUM_SRC  per-source "operand actually read" flag.
- exe_dest, mem_dest  in  REG_AW each  destination register of the instruction in EXE / MEM.
- exe_wb_en, mem_wb_en  in  1 each  writeback enable of the instruction in EXE / MEM.
- exe_mem_read  in  1  the instruction in EXE is a load.
- mem_ready  in  1  data memory ready; 0 = whole-pipeline freeze.
- branch_taken  in  1  EXE resolved a taken branch (IF/ID flush).
- stall  out  1  hold the PC and the IF/ID register.
- bubble  out  1  inject a NOP into ID/EXE.
- fwd_sel_q  out  2*NUM_SRC  registered forwarding select for the instruction now in EXE. Encoding: 00 = regfile, 01 = MEM-stage ALU result, 10 = WB-stage result, 11 = never driven.
- stall_cnt, load_use_cnt  out  CNT_W each  saturating performance counters.

Behaviour:
- Per-source matches (combinational), for each source i:
  - m_exe[i] = src_valid[i] & exe_wb_en & (src_i == exe_dest).
  - m_mem[i] = src_valid[i] & mem_wb_en & (src_i == mem_dest).
- Data hazard (combinational):
  - forward_en=0: haz = OR over all sources of (m_exe | m_mem).
  - forward_en=1: haz = OR over all sources of (m_exe & exe_mem_read). This is load-use only.
  - A match in the WB stage is never a hazard; the register file writes first.
- Output priority, highest first:
  1. rst: stall=0, bubble=0.
  2. mem_ready=0: stall=1, bubble=0. Full freeze; branch_taken and haz are ignored.
  3. branch_taken=1: stall=0, bubble=0. The pipeline flushes IF/ID; haz is ignored.
  4. haz=1: stall=1, bubble=1.
  5. Otherwise: stall=0, bubble=0.
- Stall and bubble are combinational, with zero latency from inputs.
- Next forwarding select per source (fsel_d[i]):
  - forward_en=0: 00.
  - Else if m_exe[i] & ~exe_mem_read: 01. The producer will be in MEM next cycle.
  - Else if m_mem[i]: 10. The producer will be in WB next cycle.
  - Else 00.
  - EXE match has priority over MEM match. This gives the newest value when both stages write the same register.
- fwd_sel_q register, updated on the clk rising edge:
  - rst: 0.
  - mem_ready=0: hold.
  - branch_taken or bubble: 0, since a NOP enters EXE.
  - Otherwise: load fsel_d.
- Load-use followed by forwarding:
  - Cycle t: the load is in EXE, so stall and bubble.
  - Cycle t+1: the load is in MEM and the consumer is still in ID, so m_mem=1 and fsel_d=10.
  - At the end of t+1, fwd_sel_q=10 and the consumer takes the WB-stage load data in EXE.
- Counters, updated on clk, reset to 0, saturating at all-ones (no wrap):
  - stall_cnt increments every cycle stall=1, including mem_ready freezes.
  - load_use_cnt increments on cycles where forward_en=1, mem_ready=1, branch_taken=0 and haz=1.
  - During a multi-cycle mem_ready=0 freeze, load_use_cnt does not increment.
- Reset mid-operation: all registers return to 0 on the next edge; outputs are combinationally 0 while rst=1.
- Sources with src_valid=0 never generate hazards or forwarding, whatever their address. This covers, for example, R0 placeholders or immediate operands.

Test Plan:
- Stall-only mode: forward_en=0; src0=3 valid; exe_dest=3, exe_wb_en=1 -> stall=1, bubble=1, stall_cnt 0->1. Repeat with mem_dest=3 only -> same response. Then src_valid=0 -> stall=0.
- Forwarding priority: forward_en=1; src1=5; exe_dest=5, mem_dest=5, both wb_en=1, exe_mem_read=0 -> stall=0, fwd_sel_q[3:2]=01 after the edge. With exe_wb_en=0 -> 10.
- Load-use: forward_en=1, exe_mem_read=1, exe_dest=7, src0=7 -> cycle t: stall=1, bubble=1, load_use_cnt=1. Next cycle, with mem_dest=7 and exe_wb_en=0 -> stall=0; after the edge fwd_sel_q[1:0]=10.
- Freeze vs branch: mem_ready=0 with branch_taken=1 and haz=1 -> stall=1, bubble=0, fwd_sel_q held, load_use_cnt unchanged for 5 cycles, stall_cnt +5. Then mem_ready=1, branch_taken=1 -> stall=0, fwd_sel_q=0.
- Saturation and reset: CNT_W=4, hold haz for 20 cycles -> stall_cnt stops at 15. Assert rst for 1 cycle mid-stall -> both counters and fwd_sel_q are 0 after the edge.
- Parameter sweep: NUM_SRC=1 and 4, REG_AW=5, randomised sources compared against a reference model for 10k cycles -> outputs match exactly.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - ID-stage hazard detection, operand forwarding selects and stall counters
module hazard_forward_unit #(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 3,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      forward_en,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [REG_AW-1:0]         exe_dest,
  input  logic [REG_AW-1:0]         mem_dest,
  input  logic                      exe_wb_en,
  input  logic                      mem_wb_en,
  input  logic                      exe_mem_read,
  input  logic                      mem_ready,
  input  logic                      branch_taken,
  output logic                      stall,
  output logic                      bubble,
  output logic [2*NUM_SRC-1:0]      fwd_sel_q,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          load_use_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  logic [NUM_SRC-1:0]   m_exe;
  logic [NUM_SRC-1:0]   m_mem;
  logic                 haz;
  logic [2*NUM_SRC-1:0] fsel_d;
  logic                 load_use_evt;

  always_comb begin
    m_exe  = '0;
    m_mem  = '0;
    haz    = 1'b0;
    fsel_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      m_exe[i] = src_valid[i] & exe_wb_en & (src_addr[i*REG_AW +: REG_AW] == exe_dest);
      m_mem[i] = src_valid[i] & mem_wb_en & (src_addr[i*REG_AW +: REG_AW] == mem_dest);
      if (forward_en) begin
        haz = haz | (m_exe[i] & exe_mem_read);
        // EXE producer is newer than MEM, so it wins when both write the same register
        if (m_exe[i] & ~exe_mem_read) fsel_d[2*i +: 2] = SEL_MEM;
        else if (m_mem[i])            fsel_d[2*i +: 2] = SEL_WB;
        else                          fsel_d[2*i +: 2] = SEL_RF;
      end else begin
        haz = haz | m_exe[i] | m_mem[i];
      end
    end
  end

  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    if (rst) begin
      stall  = 1'b0;
      bubble = 1'b0;
    end else if (!mem_ready) begin
      stall  = 1'b1;
    end else if (branch_taken) begin
      stall  = 1'b0;
    end else if (haz) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end
  end

  assign load_use_evt = ~rst & forward_en & mem_ready & ~branch_taken & haz;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_sel_q    <= '0;
      stall_cnt    <= '0;
      load_use_cnt <= '0;
    end else begin
      // a NOP enters EXE on flush or bubble, so it must not forward anything
      if (mem_ready) fwd_sel_q <= (branch_taken | bubble) ? '0 : fsel_d;
      if (stall && (stall_cnt != '1))           stall_cnt    <= stall_cnt + CNT_W'(1);
      if (load_use_evt && (load_use_cnt != '1)) load_use_cnt <= load_use_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed and randomized checks of hazard_forward_unit against a reference model
module tb_hazard_forward_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        a_rst, a_fe, a_ew, a_mw, a_emr, a_mr, a_bt;
  logic [11:0] a_src;
  logic [2:0]  a_sv;
  logic [3:0]  a_ed, a_md;
  logic        a_stall, a_bubble, s_stall, s_bubble;
  logic [5:0]  a_fsel, s_fsel;
  logic [15:0] a_scnt, a_lcnt;
  logic [3:0]  s_scnt, s_lcnt;

  logic        b_rst, b_fe, b_ew, b_mw, b_emr, b_mr, b_bt;
  logic [19:0] b_src;
  logic [3:0]  b_sv;
  logic [4:0]  b_ed, b_md;
  logic        c1_stall, c1_bubble, c4_stall, c4_bubble;
  logic [1:0]  c1_fsel;
  logic [7:0]  c4_fsel;
  logic [7:0]  c1_scnt, c1_lcnt, c4_scnt, c4_lcnt;

  hazard_forward_unit #(.REG_AW(4), .NUM_SRC(3), .CNT_W(16)) dut (
    .clk(clk), .rst(a_rst), .forward_en(a_fe), .src_addr(a_src), .src_valid(a_sv),
    .exe_dest(a_ed), .mem_dest(a_md), .exe_wb_en(a_ew), .mem_wb_en(a_mw),
    .exe_mem_read(a_emr), .mem_ready(a_mr), .branch_taken(a_bt),
    .stall(a_stall), .bubble(a_bubble), .fwd_sel_q(a_fsel),
    .stall_cnt(a_scnt), .load_use_cnt(a_lcnt));

  hazard_forward_unit #(.REG_AW(4), .NUM_SRC(3), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(a_rst), .forward_en(a_fe), .src_addr(a_src), .src_valid(a_sv),
    .exe_dest(a_ed), .mem_dest(a_md), .exe_wb_en(a_ew), .mem_wb_en(a_mw),
    .exe_mem_read(a_emr), .mem_ready(a_mr), .branch_taken(a_bt),
    .stall(s_stall), .bubble(s_bubble), .fwd_sel_q(s_fsel),
    .stall_cnt(s_scnt), .load_use_cnt(s_lcnt));

  hazard_forward_unit #(.REG_AW(5), .NUM_SRC(1), .CNT_W(8)) dut_n1 (
    .clk(clk), .rst(b_rst), .forward_en(b_fe), .src_addr(b_src[4:0]), .src_valid(b_sv[0]),
    .exe_dest(b_ed), .mem_dest(b_md), .exe_wb_en(b_ew), .mem_wb_en(b_mw),
    .exe_mem_read(b_emr), .mem_ready(b_mr), .branch_taken(b_bt),
    .stall(c1_stall), .bubble(c1_bubble), .fwd_sel_q(c1_fsel),
    .stall_cnt(c1_scnt), .load_use_cnt(c1_lcnt));

  hazard_forward_unit #(.REG_AW(5), .NUM_SRC(4), .CNT_W(8)) dut_n4 (
    .clk(clk), .rst(b_rst), .forward_en(b_fe), .src_addr(b_src), .src_valid(b_sv),
    .exe_dest(b_ed), .mem_dest(b_md), .exe_wb_en(b_ew), .mem_wb_en(b_mw),
    .exe_mem_read(b_emr), .mem_ready(b_mr), .branch_taken(b_bt),
    .stall(c4_stall), .bubble(c4_bubble), .fwd_sel_q(c4_fsel),
    .stall_cnt(c4_scnt), .load_use_cnt(c4_lcnt));

  int exp_sc = 0;
  int exp_lc = 0;

  // reference model state for the two swept instances (index 0: one source, 1: four sources)
  int mq [2][4];
  int mfs[2][4];
  int msc[2];
  int mlc[2];
  bit mst[2];
  bit mbb[2];
  bit mh [2];

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    a_fe = 1'b0; a_src = '0; a_sv = '0; a_ed = '0; a_md = '0;
    a_ew = 1'b0; a_mw = 1'b0; a_emr = 1'b0; a_mr = 1'b1; a_bt = 1'b0;
  endtask

  task automatic model_comb(input int k, input int n);
    bit me, mm;
    int s;
    mh[k] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mfs[k][i] = 0;
      if (i < n) begin
        s  = int'(b_src[i*5 +: 5]);
        me = b_sv[i] && b_ew && (s == int'(b_ed));
        mm = b_sv[i] && b_mw && (s == int'(b_md));
        if (b_fe) mh[k] = mh[k] || (me && b_emr);
        else      mh[k] = mh[k] || me || mm;
        if (b_fe && me && !b_emr) mfs[k][i] = 1;
        else if (b_fe && mm)      mfs[k][i] = 2;
      end
    end
    if (b_rst)       begin mst[k] = 0; mbb[k] = 0; end
    else if (!b_mr)  begin mst[k] = 1; mbb[k] = 0; end
    else if (b_bt)   begin mst[k] = 0; mbb[k] = 0; end
    else             begin mst[k] = mh[k]; mbb[k] = mh[k]; end
  endtask

  task automatic model_update(input int k);
    if (b_rst) begin
      msc[k] = 0; mlc[k] = 0;
      for (int i = 0; i < 4; i++) mq[k][i] = 0;
    end else begin
      if (mst[k]) msc[k] = sat(msc[k] + 1, 255);
      if (b_fe && b_mr && !b_bt && mh[k]) mlc[k] = sat(mlc[k] + 1, 255);
      if (b_mr) for (int i = 0; i < 4; i++) mq[k][i] = (b_bt || mbb[k]) ? 0 : mfs[k][i];
    end
  endtask

  task automatic test_reset();
    a_rst = 1'b1;
    drive_idle();
    a_src = 12'h003; a_sv = 3'b001; a_ed = 4'd3; a_ew = 1'b1;
    #1;
    checks++;
    if ({a_stall, a_bubble, s_stall, s_bubble} !== 4'b0000) begin
      failures++; $display("FAIL reset_comb got=%b exp=0000", {a_stall, a_bubble, s_stall, s_bubble});
    end
    tick();
    checks++;
    if ({a_fsel, a_scnt, a_lcnt} !== 38'd0) begin
      failures++; $display("FAIL reset_regs got fsel=%b scnt=%0d lcnt=%0d exp 0", a_fsel, a_scnt, a_lcnt);
    end
    checks++;
    if ({s_fsel, s_scnt, s_lcnt} !== 14'd0) begin
      failures++; $display("FAIL reset_regs_sat got fsel=%b scnt=%0d lcnt=%0d exp 0", s_fsel, s_scnt, s_lcnt);
    end
    a_rst = 1'b0;
    exp_sc = 0; exp_lc = 0;
  endtask

  task automatic test_stall_only();
    logic [1:0] exp_sb [3];
    exp_sb[0] = 2'b11; exp_sb[1] = 2'b11; exp_sb[2] = 2'b00;
    drive_idle();
    a_src = 12'h003; a_sv = 3'b001;
    for (int step = 0; step < 3; step++) begin
      case (step)
        0: begin a_ed = 4'd3; a_ew = 1'b1; end
        1: begin a_ew = 1'b0; a_md = 4'd3; a_mw = 1'b1; end
        default: a_sv = 3'b000;
      endcase
      #1;
      checks++;
      if ({a_stall, a_bubble} !== exp_sb[step]) begin
        failures++; $display("FAIL stall_only_%0d got=%b exp=%b", step, {a_stall, a_bubble}, exp_sb[step]);
      end
      tick();
      if (exp_sb[step][1]) exp_sc++;
      checks++;
      if ({a_scnt, a_lcnt, a_fsel} !== {16'(exp_sc), 16'(exp_lc), 6'b0}) begin
        failures++; $display("FAIL stall_only_regs_%0d got scnt=%0d lcnt=%0d fsel=%b exp %0d %0d 0", step, a_scnt, a_lcnt, a_fsel, exp_sc, exp_lc);
      end
    end
  endtask

  task automatic test_forward_priority();
    drive_idle();
    a_fe = 1'b1; a_src = 12'h050; a_sv = 3'b010;
    a_ed = 4'd5; a_md = 4'd5; a_ew = 1'b1; a_mw = 1'b1; a_emr = 1'b0;
    #1;
    checks++;
    if ({a_stall, a_bubble} !== 2'b00) begin
      failures++; $display("FAIL fwd_no_stall got=%b exp=00", {a_stall, a_bubble});
    end
    tick();
    checks++;
    if (a_fsel !== 6'b000100) begin
      failures++; $display("FAIL fwd_exe_priority got=%b exp=000100", a_fsel);
    end
    a_ew = 1'b0;
    tick();
    checks++;
    if (a_fsel !== 6'b001000) begin
      failures++; $display("FAIL fwd_mem_only got=%b exp=001000", a_fsel);
    end
    a_sv = 3'b000;
    tick();
    checks++;
    if (a_fsel !== 6'b000000) begin
      failures++; $display("FAIL fwd_invalid_src got=%b exp=000000", a_fsel);
    end
  endtask

  task automatic test_load_use();
    drive_idle();
    a_fe = 1'b1; a_emr = 1'b1; a_ed = 4'd7; a_ew = 1'b1; a_src = 12'h007; a_sv = 3'b001;
    #1;
    checks++;
    if ({a_stall, a_bubble} !== 2'b11) begin
      failures++; $display("FAIL load_use_stall got=%b exp=11", {a_stall, a_bubble});
    end
    tick();
    exp_sc++; exp_lc++;
    checks++;
    if ({a_scnt, a_lcnt, a_fsel} !== {16'(exp_sc), 16'(exp_lc), 6'b0}) begin
      failures++; $display("FAIL load_use_regs got scnt=%0d lcnt=%0d fsel=%b exp %0d %0d 0", a_scnt, a_lcnt, a_fsel, exp_sc, exp_lc);
    end
    a_ew = 1'b0; a_emr = 1'b0; a_md = 4'd7; a_mw = 1'b1;
    #1;
    checks++;
    if ({a_stall, a_bubble} !== 2'b00) begin
      failures++; $display("FAIL load_use_release got=%b exp=00", {a_stall, a_bubble});
    end
    tick();
    checks++;
    if (a_fsel !== 6'b000010) begin
      failures++; $display("FAIL load_use_wb_fwd got=%b exp=000010", a_fsel);
    end
  endtask

  task automatic test_freeze_branch();
    a_mr = 1'b0; a_bt = 1'b1; a_fe = 1'b1; a_emr = 1'b1; a_ed = 4'd7; a_ew = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({a_stall, a_bubble} !== 2'b10) begin
        failures++; $display("FAIL freeze_comb_%0d got=%b exp=10", k, {a_stall, a_bubble});
      end
      tick();
      exp_sc++;
      checks++;
      if ({a_fsel, a_scnt, a_lcnt} !== {6'b000010, 16'(exp_sc), 16'(exp_lc)}) begin
        failures++; $display("FAIL freeze_regs_%0d got fsel=%b scnt=%0d lcnt=%0d exp 000010 %0d %0d", k, a_fsel, a_scnt, a_lcnt, exp_sc, exp_lc);
      end
    end
    a_mr = 1'b1;
    #1;
    checks++;
    if ({a_stall, a_bubble} !== 2'b00) begin
      failures++; $display("FAIL branch_comb got=%b exp=00", {a_stall, a_bubble});
    end
    tick();
    checks++;
    if ({a_fsel, a_scnt, a_lcnt} !== {6'b0, 16'(exp_sc), 16'(exp_lc)}) begin
      failures++; $display("FAIL branch_regs got fsel=%b scnt=%0d lcnt=%0d exp 0 %0d %0d", a_fsel, a_scnt, a_lcnt, exp_sc, exp_lc);
    end
  endtask

  task automatic test_saturation();
    drive_idle();
    a_fe = 1'b1; a_emr = 1'b1; a_ed = 4'd7; a_ew = 1'b1; a_src = 12'h007; a_sv = 3'b001;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp_sc++; exp_lc++;
      checks++;
      if ({s_scnt, s_lcnt, a_scnt, a_lcnt} !== {4'(sat(exp_sc, 15)), 4'(sat(exp_lc, 15)), 16'(exp_sc), 16'(exp_lc)}) begin
        failures++; $display("FAIL saturation_%0d got sat=%0d/%0d wide=%0d/%0d exp %0d/%0d %0d/%0d", k, s_scnt, s_lcnt, a_scnt, a_lcnt, sat(exp_sc, 15), sat(exp_lc, 15), exp_sc, exp_lc);
      end
    end
    a_rst = 1'b1;
    #1;
    checks++;
    if ({a_stall, a_bubble, s_stall, s_bubble} !== 4'b0000) begin
      failures++; $display("FAIL mid_reset_comb got=%b exp=0000", {a_stall, a_bubble, s_stall, s_bubble});
    end
    tick();
    a_rst = 1'b0;
    exp_sc = 0; exp_lc = 0;
    checks++;
    if ({a_fsel, a_scnt, a_lcnt, s_fsel, s_scnt, s_lcnt} !== 52'd0) begin
      failures++; $display("FAIL mid_reset_regs got %0d/%0d/%0d %0d/%0d exp 0", a_scnt, a_lcnt, s_scnt, s_lcnt, a_fsel);
    end
    #1;
    checks++;
    if ({a_stall, a_bubble} !== 2'b11) begin
      failures++; $display("FAIL post_reset_stall got=%b exp=11", {a_stall, a_bubble});
    end
    tick();
    checks++;
    if ({a_scnt, a_lcnt} !== {16'd1, 16'd1}) begin
      failures++; $display("FAIL post_reset_count got=%0d/%0d exp 1/1", a_scnt, a_lcnt);
    end
  endtask

  task automatic test_random();
    logic [1:0] e1;
    logic [7:0] e4;
    for (int k = 0; k < 2; k++) begin
      msc[k] = 0; mlc[k] = 0;
      for (int i = 0; i < 4; i++) mq[k][i] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      b_rst = ($urandom_range(0, 99) < 2);
      b_fe  = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++)
        b_src[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      b_sv  = 4'($urandom);
      b_ed  = 5'($urandom_range(0, 3));
      b_md  = 5'($urandom_range(0, 3));
      b_ew  = 1'($urandom);
      b_mw  = 1'($urandom);
      b_emr = 1'($urandom);
      b_mr  = ($urandom_range(0, 99) >= 15);
      b_bt  = ($urandom_range(0, 99) < 10);
      #1;
      model_comb(0, 1);
      model_comb(1, 4);
      checks++;
      if ({c1_stall, c1_bubble} !== {mst[0], mbb[0]}) begin
        failures++; $display("FAIL rand_n1_comb cyc=%0d got=%b exp=%b", cyc, {c1_stall, c1_bubble}, {mst[0], mbb[0]});
      end
      checks++;
      if ({c4_stall, c4_bubble} !== {mst[1], mbb[1]}) begin
        failures++; $display("FAIL rand_n4_comb cyc=%0d got=%b exp=%b", cyc, {c4_stall, c4_bubble}, {mst[1], mbb[1]});
      end
      @(posedge clk);
      model_update(0);
      model_update(1);
      #1;
      e1 = 2'(mq[0][0]);
      for (int i = 0; i < 4; i++) e4[2*i +: 2] = 2'(mq[1][i]);
      checks++;
      if ({c1_fsel, c1_scnt, c1_lcnt} !== {e1, 8'(msc[0]), 8'(mlc[0])}) begin
        failures++; $display("FAIL rand_n1_regs cyc=%0d got fsel=%b scnt=%0d lcnt=%0d exp %b %0d %0d", cyc, c1_fsel, c1_scnt, c1_lcnt, e1, msc[0], mlc[0]);
      end
      checks++;
      if ({c4_fsel, c4_scnt, c4_lcnt} !== {e4, 8'(msc[1]), 8'(mlc[1])}) begin
        failures++; $display("FAIL rand_n4_regs cyc=%0d got fsel=%b scnt=%0d lcnt=%0d exp %b %0d %0d", cyc, c4_fsel, c4_scnt, c4_lcnt, e4, msc[1], mlc[1]);
      end
    end
  endtask

  initial begin
    a_rst = 1'b1;
    drive_idle();
    b_rst = 1'b1; b_fe = 1'b0; b_src = '0; b_sv = '0; b_ed = '0; b_md = '0;
    b_ew = 1'b0; b_mw = 1'b0; b_emr = 1'b0; b_mr = 1'b1; b_bt = 1'b0;
    test_reset();
    test_stall_only();
    test_forward_priority();
    test_load_use();
    test_freeze_branch();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
